// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundle of the two requester ports and the shared memory port of mem_arbiter.
//
// Parameters:
//   ADDR_W  memory address width
//   DATA_W  memory data width
//
// Signals:
//   req0/req1, addr0/addr1, wdata0/wdata1, we0/we1   requester side (CPU = 0,
//                                                     program loader = 1)
//   gnt0/gnt1, rvalid0/rvalid1                        registered grant / read valid
//   mem_addr, mem_wdata, mem_we                       muxed memory access
//   busy                                              any port granted
//
// Modports:
//   master  requester side (drives requests, observes grants and memory port)
//   slave   arbiter side
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              we0;
  logic              we1;
  logic              gnt0;
  logic              gnt1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              rvalid0;
  logic              rvalid1;
  logic              busy;

  modport master (
    output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
    input  gnt0, gnt1, mem_addr, mem_wdata, mem_we, rvalid0, rvalid1, busy
  );

  modport slave (
    input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
    output gnt0, gnt1, mem_addr, mem_wdata, mem_we, rvalid0, rvalid1, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-port round-robin arbiter in front of a single synchronous memory port.
// Port 0 is the CPU, port 1 the program loader. A granted port keeps the
// memory as long as it holds its request; when it lets go, a waiting port is
// granted on the very next cycle with no idle gap.
//
// Optional feature (macro ARB_TIMEOUT_EN): a port that has owned the memory
// for MAX_HOLD consecutive cycles is preempted if the other port is waiting.
// Without the macro there is no preemption and MAX_HOLD has no effect.
//
// Parameters:
//   ADDR_W    memory address width
//   DATA_W    memory data width
//   MAX_HOLD  consecutive granted cycles before forced release (2..255)
//
// Ports:
//   clk    clock, all state on the rising edge
//   reset  synchronous, active-low reset
//   bus    mem_arbiter_if.slave (requests, grants, memory port, rvalid, busy)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   last_reg;      // port served most recently; 1 after reset so CPU wins first tie
  logic   gnt0_reg;
  logic   gnt1_reg;
  logic   rvalid0_reg;
  logic   rvalid1_reg;

  // Out-of-range MAX_HOLD leaves this marker block in the elaborated hierarchy.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_out_of_range
  end

`ifdef ARB_TIMEOUT_EN
  // hold_cnt_reg is 0 in the first cycle of an ownership, so the owner has
  // used MAX_HOLD cycles once it reaches MAX_HOLD-1.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_reg;
`endif

  // Next-state decision
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_next = last_reg ? OWN0 : OWN1;
        end else if (bus.req0) begin
          state_next = OWN0;
        end else if (bus.req1) begin
          state_next = OWN1;
        end
      end
      OWN0: begin
        if (!bus.req0) begin
          state_next = bus.req1 ? OWN1 : IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (bus.req1 && hold_cnt_reg >= HOLD_LAST) begin
          state_next = OWN1;
        end
`endif
      end
      OWN1: begin
        if (!bus.req1) begin
          state_next = bus.req0 ? OWN0 : IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (bus.req0 && hold_cnt_reg >= HOLD_LAST) begin
          state_next = OWN0;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      last_reg    <= 1'b1;
      gnt0_reg    <= 1'b0;
      gnt1_reg    <= 1'b0;
      rvalid0_reg <= 1'b0;
      rvalid1_reg <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_reg <= 8'd0;
`endif
    end else begin
      state_reg <= state_next;
      gnt0_reg  <= (state_next == OWN0);
      gnt1_reg  <= (state_next == OWN1);
      if (state_next == OWN0) begin
        last_reg <= 1'b0;
      end else if (state_next == OWN1) begin
        last_reg <= 1'b1;
      end
      // A read issued this cycle returns data from the memory next cycle.
      rvalid0_reg <= gnt0_reg & bus.req0 & ~bus.we0;
      rvalid1_reg <= gnt1_reg & bus.req1 & ~bus.we1;
`ifdef ARB_TIMEOUT_EN
      if (state_next != state_reg || state_reg == IDLE) begin
        hold_cnt_reg <= 8'd0;
      end else if (hold_cnt_reg != 8'hFF) begin
        hold_cnt_reg <= hold_cnt_reg + 8'd1;
      end
`endif
    end
  end

  assign bus.gnt0    = gnt0_reg;
  assign bus.gnt1    = gnt1_reg;
  assign bus.rvalid0 = rvalid0_reg;
  assign bus.rvalid1 = rvalid1_reg;
  assign bus.busy    = gnt0_reg | gnt1_reg;

  // Memory port follows the current grant combinationally.
  always_comb begin
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    bus.mem_we    = 1'b0;
    if (gnt0_reg) begin
      bus.mem_addr  = bus.addr0;
      bus.mem_wdata = bus.wdata0;
      bus.mem_we    = bus.req0 & bus.we0;
    end else if (gnt1_reg) begin
      bus.mem_addr  = bus.addr1;
      bus.mem_wdata = bus.wdata1;
      bus.mem_we    = bus.req1 & bus.we1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. Directed scenarios first, then
// randomized requesters checked cycle by cycle against a behavioural model
// that tracks the owner as an integer and the ownership length in cycles.
// Build with +define+ARB_TIMEOUT_EN to check the timeout variant.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- stimulus state ----------------
  bit          rst_n;
  bit          req  [2];
  bit          we   [2];
  logic [7:0]  addr [2];
  logic [7:0]  wdata[2];

  // ---------------- reference model ----------------
  int  owner       = -1;   // -1 none, else granted port
  int  last_served = 1;
  int  held        = 0;    // cycles the current owner has had the memory
  bit  exp_rv[2];
  bit  model_valid = 0;

  task automatic set_port(input int p, input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
    req[p] = r; we[p] = w; addr[p] = a; wdata[p] = d;
  endtask

  task automatic drive();
    reset      = rst_n;
    bus.req0   = req[0];  bus.req1   = req[1];
    bus.we0    = we[0];   bus.we1    = we[1];
    bus.addr0  = addr[0]; bus.addr1  = addr[1];
    bus.wdata0 = wdata[0]; bus.wdata1 = wdata[1];
  endtask

  // Advance the model across one rising edge using the inputs present there.
  task automatic model_step();
    int nxt;
    if (!rst_n) begin
      owner = -1; last_served = 1; held = 0;
      exp_rv[0] = 0; exp_rv[1] = 0;
      model_valid = 1;
      return;
    end
    for (int p = 0; p < 2; p++) begin
      exp_rv[p] = (owner == p) && req[p] && !we[p];
      if (owner == p && req[p])
        $display("[TB] t=%0t port%0d %s addr=0x%02h data=0x%02h", $time, p,
                 we[p] ? "write" : "read ", addr[p], wdata[p]);
    end
    nxt = owner;
    if (owner < 0) begin
      if (req[0] && req[1]) nxt = (last_served == 1) ? 0 : 1;
      else if (req[0])      nxt = 0;
      else if (req[1])      nxt = 1;
    end else begin
      if (!req[owner]) nxt = req[1-owner] ? 1 - owner : -1;
`ifdef ARB_TIMEOUT_EN
      else if (req[1-owner] && held >= MAX_HOLD) nxt = 1 - owner;
`endif
    end
    if (nxt >= 0 && nxt == owner) held++;
    else held = (nxt >= 0) ? 1 : 0;
    if (nxt >= 0) last_served = nxt;
    owner = nxt;
  endtask

  task automatic check_comb();
    logic [7:0] ea, ed;
    bit ew;
    if (!model_valid) return;
    ea = 8'h00; ed = 8'h00; ew = 1'b0;
    if (owner >= 0) begin
      ea = addr[owner]; ed = wdata[owner]; ew = req[owner] && we[owner];
    end
    check("mem_addr",  32'(bus.mem_addr),  32'(ea));
    check("mem_wdata", 32'(bus.mem_wdata), 32'(ed));
    check("mem_we",    32'(bus.mem_we),    32'(ew));
    check("gnt_excl",  32'(bus.gnt0 & bus.gnt1), 32'(0));
    check("we_idle",   32'(bus.mem_we & ~bus.busy), 32'(0));
  endtask

  task automatic check_regs();
    check("gnt0",    32'(bus.gnt0),    32'(owner == 0));
    check("gnt1",    32'(bus.gnt1),    32'(owner == 1));
    check("busy",    32'(bus.busy),    32'(owner >= 0));
    check("rvalid0", 32'(bus.rvalid0), 32'(exp_rv[0]));
    check("rvalid1", 32'(bus.rvalid1), 32'(exp_rv[1]));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs checked between edges.
  task automatic drive_phase();
    drive();
    #1;
    check_comb();
  endtask

  task automatic clock_phase();
    @(posedge clk);
    #1;
    model_step();
    check_regs();
  endtask

  task automatic cycle();
    drive_phase();
    clock_phase();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    bit ended;
    rst_n = 0;
    set_port(0, 0, 0, 8'h00, 8'h00);
    set_port(1, 0, 0, 8'h00, 8'h00);

    // Reset state
    repeat (3) cycle();
    check("rst_gnt0",    32'(bus.gnt0),    32'(0));
    check("rst_gnt1",    32'(bus.gnt1),    32'(0));
    check("rst_rvalid0", 32'(bus.rvalid0), 32'(0));
    check("rst_busy",    32'(bus.busy),    32'(0));

    // CPU read of 0x10 right after reset release
    rst_n = 1;
    set_port(0, 1, 0, 8'h10, 8'h00);
    cycle();
    check("rd_gnt0", 32'(bus.gnt0), 32'(1));
    drive_phase();
    check("rd_addr", 32'(bus.mem_addr), 32'h10);
    clock_phase();
    check("rd_rvalid0", 32'(bus.rvalid0), 32'(1));
    set_port(0, 0, 0, 8'h10, 8'h00);
    cycle();

    // Tie after reset, handover without idle gap, later tie back to port 0
    rst_n = 0; cycle(); rst_n = 1;
    set_port(0, 1, 0, 8'h21, 8'h00);
    set_port(1, 1, 0, 8'h31, 8'h00);
    cycle();
    check("tie_gnt0", 32'(bus.gnt0), 32'(1));
    set_port(0, 0, 0, 8'h21, 8'h00);
    cycle();
    check("handover_gnt1", 32'(bus.gnt1), 32'(1));
    check("handover_busy", 32'(bus.busy), 32'(1));
    set_port(1, 0, 0, 8'h31, 8'h00);
    cycle();
    set_port(0, 1, 0, 8'h22, 8'h00);
    set_port(1, 1, 0, 8'h32, 8'h00);
    cycle();
    check("tie2_gnt0", 32'(bus.gnt0), 32'(1));
    set_port(0, 0, 0, 8'h00, 8'h00);
    set_port(1, 0, 0, 8'h00, 8'h00);
    cycle();

    // Loader write 0x3F <= 0xA5
    set_port(1, 1, 1, 8'h3F, 8'hA5);
    cycle();
    drive_phase();
    check("wr_we",    32'(bus.mem_we),    32'(1));
    check("wr_addr",  32'(bus.mem_addr),  32'h3F);
    check("wr_wdata", 32'(bus.mem_wdata), 32'hA5);
    clock_phase();
    check("wr_rvalid1", 32'(bus.rvalid1), 32'(0));
    set_port(1, 0, 0, 8'h00, 8'h00);
    cycle();

    // Reset during a granted loader read aborts it
    set_port(1, 1, 0, 8'h22, 8'h00);
    cycle();
    rst_n = 0;
    cycle();
    check("abort_gnt1",    32'(bus.gnt1),    32'(0));
    check("abort_rvalid1", 32'(bus.rvalid1), 32'(0));
    check("abort_busy",    32'(bus.busy),    32'(0));
    rst_n = 1;
    set_port(1, 0, 0, 8'h00, 8'h00);
    cycle();

    // Long CPU hold with loader waiting
    set_port(0, 1, 0, 8'h40, 8'h00);
    cycle();
    set_port(1, 1, 0, 8'h41, 8'h00);
    run = 1; ended = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (!ended && bus.gnt0) run++;
      else ended = 1;
    end
`ifdef ARB_TIMEOUT_EN
    check("hold_len", 32'(run), 32'(MAX_HOLD));
`else
    check("hold_len", 32'(run), 32'(13));
`endif
    set_port(0, 0, 0, 8'h00, 8'h00);
    set_port(1, 0, 0, 8'h00, 8'h00);
    repeat (2) cycle();

    // Randomized requesters; a waiting requester keeps its fields stable.
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      for (int p = 0; p < 2; p++) begin
        if (owner == p) begin
          req[p] = ($urandom_range(0, 4) != 0);
          if (req[p]) set_port(p, 1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end else if (!req[p] && $urandom_range(0, 2) == 0) begin
          set_port(p, 1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
